// File: rtl/config_stream_driver.sv
// Transmit driver for the tile configuration shift chain: serializes one word
// MSB-first onto the hard or soft line, pulses the set strobes, then idles a gap.
module config_stream_driver #(
    parameter int CHAIN_LEN  = 12,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHAIN_LEN-1:0] cfg_data,
    input  logic                 cfg_path,
    input  logic [1:0]           cfg_set,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 shift_hard,
    output logic                 shift_soft,
    output logic                 shift_enable,
    output logic                 set_hard,
    output logic                 set_soft,
    output logic                 done
);

    localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CHAIN_LEN - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, SET, GAP} state_t;

    state_t                 state_q, state_d;
    logic [CHAIN_LEN-1:0]   data_q, data_d;
    logic                   path_q, path_d;
    logic [1:0]             set_q, set_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [GW-1:0]          gap_q, gap_d;

    logic ready_q, ready_d;
    logic shift_hard_q, shift_hard_d;
    logic shift_soft_q, shift_soft_d;
    logic shift_enable_q, shift_enable_d;
    logic set_hard_q, set_hard_d;
    logic set_soft_q, set_soft_d;
    logic done_q, done_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        path_d  = path_q;
        set_d   = set_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;

        case (state_q)
            IDLE: begin
                if (cfg_valid && ready_q) begin
                    state_d = SHIFT;
                    data_d  = cfg_data;
                    path_d  = cfg_path;
                    set_d   = cfg_set;
                    cnt_d   = CNT_LOAD;
                end
            end
            SHIFT: begin
                // Word register shifts left so the outgoing bit is always the MSB.
                if (cnt_q == '0) begin
                    state_d = SET;
                end else begin
                    cnt_d  = cnt_q - CW'(1);
                    data_d = data_q << 1;
                end
            end
            SET: begin
                if (GAP_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are precomputed from next-state values so they register cleanly.
        ready_d        = (state_d == IDLE);
        shift_enable_d = (state_d == SHIFT);
        shift_hard_d   = (state_d == SHIFT) && !path_d && data_d[CHAIN_LEN-1];
        shift_soft_d   = (state_d == SHIFT) &&  path_d && data_d[CHAIN_LEN-1];
        set_hard_d     = (state_d == SET) && set_d[1];
        set_soft_d     = (state_d == SET) && set_d[0];
        done_d         = (state_d == SET);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            data_q         <= '0;
            path_q         <= 1'b0;
            set_q          <= '0;
            cnt_q          <= '0;
            gap_q          <= '0;
            ready_q        <= 1'b0;
            shift_hard_q   <= 1'b0;
            shift_soft_q   <= 1'b0;
            shift_enable_q <= 1'b0;
            set_hard_q     <= 1'b0;
            set_soft_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            data_q         <= data_d;
            path_q         <= path_d;
            set_q          <= set_d;
            cnt_q          <= cnt_d;
            gap_q          <= gap_d;
            ready_q        <= ready_d;
            shift_hard_q   <= shift_hard_d;
            shift_soft_q   <= shift_soft_d;
            shift_enable_q <= shift_enable_d;
            set_hard_q     <= set_hard_d;
            set_soft_q     <= set_soft_d;
            done_q         <= done_d;
        end
    end

    assign cfg_ready    = ready_q;
    assign shift_hard   = shift_hard_q;
    assign shift_soft   = shift_soft_q;
    assign shift_enable = shift_enable_q;
    assign set_hard     = set_hard_q;
    assign set_soft     = set_soft_q;
    assign done         = done_q;

endmodule
